// File: rtl/store_buffer_if.sv
// Write-side bus between the store buffer and the backing data RAM, plus the
// RAM's combinational read port used for loads.
interface store_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rd;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_raddr,
    input  mem_ack, mem_rd
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_raddr,
    output mem_ack, mem_rd
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and the data RAM, with in-order
// draining over a req/ack handshake and youngest-match store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [31:0]              a,
  input  logic [31:0]              wd,
  output logic [31:0]              rd,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  store_buffer_if.master           mem
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]   addr_q [DEPTH];
  logic [29:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, empty_s, push_s, pop_s;

  // Occupancy flags and handshake qualifiers; full blocks a push even when a pop
  // happens in the same cycle, which keeps mem_ack out of the stall path.
  always_comb begin
    full_s  = (count_q == CW'(DEPTH));
    empty_s = (count_q == {CW{1'b0}});
    push_s  = we & ~full_s;
    pop_s   = ~empty_s & mem.mem_ack;
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push_s) begin
      addr_d[tail_q] = a[31:2];
      data_d[tail_q] = wd;
      tail_d         = tail_q + PW'(1'b1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PW'(1'b1);
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards queued stores and clears the storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 30'd0;
        data_q[i] <= 32'd0;
      end
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    rd = mem.mem_rd;
    for (int i = 0; i < DEPTH; i++) begin
      rd = ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == a[31:2]))
           ? data_q[head_q + PW'(i)] : rd;
    end
  end

  // Core-side and RAM-side outputs.
  always_comb begin
    stall         = we & full_s;
    count         = count_q;
    empty         = empty_s;
    mem.mem_req   = ~empty_s;
    mem.mem_addr  = {addr_q[head_q], 2'b00};
    mem.mem_wdata = data_q[head_q];
    mem.mem_raddr = a;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue scoreboard of accepted stores,
// compared against the RAM write bus on every handshake.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic [2:0]  count;
  logic        empty;

  int          checks   = 0;
  int          failures = 0;
  int          mcount   = 0;
  logic [63:0] sb [$];

  store_buffer_if mem ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .stall (stall),
    .count (count),
    .empty (empty),
    .mem   (mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the inputs already driven: checks the combinational
  // outputs, scores any handshake, then checks occupancy after the edge.
  task automatic tick(input string tag);
    logic        acc;
    logic        pp;
    logic [63:0] e;
    #2;
    chk({tag, ":stall"},   32'(stall),       32'(we && (mcount == DEPTH)));
    chk({tag, ":mem_req"}, 32'(mem.mem_req), 32'(mcount != 0));
    acc = we && (mcount < DEPTH);
    pp  = mem.mem_ack && (mcount > 0);
    if (pp) begin
      e = sb.pop_front();
      chk({tag, ":drain_addr"},  mem.mem_addr,  e[63:32]);
      chk({tag, ":drain_wdata"}, mem.mem_wdata, e[31:0]);
    end
    if (acc) sb.push_back({a[31:2], 2'b00, wd});
    @(posedge clk);
    #1;
    mcount = mcount + (acc ? 1 : 0) - (pp ? 1 : 0);
    chk({tag, ":count"}, 32'(count), 32'(mcount));
    chk({tag, ":empty"}, 32'(empty), 32'(mcount == 0));
  endtask

  initial begin
    reset       = 1'b1;
    we          = 1'b0;
    a           = 32'h0000_0040;
    wd          = 32'h0;
    mem.mem_ack = 1'b0;
    mem.mem_rd  = 32'h1234_5678;
    #12;
    chk("rst:count",   32'(count),       32'd0);
    chk("rst:empty",   32'(empty),       32'd1);
    chk("rst:mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst:stall",   32'(stall),       32'd0);
    chk("rst:addr",    mem.mem_addr,     32'h0);
    chk("rst:wdata",   mem.mem_wdata,    32'h0);
    chk("rst:rd",      rd,               32'h1234_5678);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single store then one-cycle ack
    we = 1'b1; a = 32'h40; wd = 32'h11;
    tick("single_push");
    we = 1'b0;
    chk("single:mem_addr",  mem.mem_addr,  32'h40);
    chk("single:mem_wdata", mem.mem_wdata, 32'h11);
    mem.mem_ack = 1'b1;
    tick("single_pop");
    mem.mem_ack = 1'b0;

    // Fill, stall, and acceptance on the cycle after the first pop
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; a = 32'(i * 4); wd = 32'h100 + 32'(i);
      tick("fill");
    end
    a = 32'h10; wd = 32'h104;
    tick("fill_stall");
    mem.mem_ack = 1'b1;
    tick("fill_stall_pop");
    mem.mem_ack = 1'b0;
    tick("fill_accept");
    we = 1'b0; mem.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick("fill_drain");
    mem.mem_ack = 1'b0;

    // Forwarding picks the youngest matching store
    we = 1'b1; a = 32'h20; wd = 32'hA;
    tick("fwd_push_a");
    wd = 32'hB;
    tick("fwd_push_b");
    we = 1'b0; mem.mem_rd = 32'hDEAD;
    #1 chk("fwd:rd_youngest", rd, 32'hB);
    a = 32'h24;
    #1 chk("fwd:rd_nomatch", rd, 32'hDEAD);
    a = 32'h20; mem.mem_ack = 1'b1;
    tick("fwd_pop1");
    chk("fwd:rd_after_pop1", rd, 32'hB);
    tick("fwd_pop2");
    chk("fwd:rd_after_pop2", rd, 32'hDEAD);
    mem.mem_ack = 1'b0;

    // Simultaneous push and pop across the pointer wrap
    we = 1'b1; a = 32'h30; wd = 32'h200;
    tick("pp_pre0");
    wd = 32'h201;
    tick("pp_pre1");
    mem.mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wd = 32'h202 + 32'(i);
      tick("pp_steady");
      chk("pp:rd_youngest", rd, 32'h202 + 32'(i));
    end
    we = 1'b0;
    tick("pp_drain");
    tick("pp_drain");
    mem.mem_ack = 1'b0;

    // Reset in the middle of a pending handshake
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; a = 32'h50 + 32'(i * 4); wd = 32'h300 + 32'(i);
      tick("mid_fill");
    end
    chk("mid:mem_req_before", 32'(mem.mem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid:mem_req", 32'(mem.mem_req), 32'd0);
    chk("mid:count",   32'(count),       32'd0);
    chk("mid:stall",   32'(stall),       32'd0);
    #2;
    reset = 1'b0; we = 1'b0; a = 32'h50; mem.mem_rd = 32'hBEEF;
    sb.delete();
    mcount = 0;
    #1 chk("mid:rd_after_reset", rd, 32'hBEEF);
    @(posedge clk);
    #1;

    // Ack while empty is ignored; a later store drains one cycle after acceptance
    mem.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) tick("spur_idle");
    we = 1'b1; a = 32'h44; wd = 32'h7;
    tick("spur_push");
    we = 1'b0;
    chk("spur:mem_addr", mem.mem_addr, 32'h44);
    tick("spur_drain");
    mem.mem_ack = 1'b0;
    tick("spur_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
